// File: rtl/uc_sequencer.sv
// Micro-sequencer: runs a 16-entry program of ALU / RAM-write / RAM-read / HALT
// instructions against an external microcontroller, three cycles per instruction.
// Optional result signature register enabled by defining UC_SEQ_SIG_EN.
module uc_sequencer #(
    parameter logic [3:0] LAST_PC = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [11:0] prog_data,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [1:0]  opcode,
    output logic [3:0]  ram_addr,
    output logic [3:0]  ram_din,
    output logic        ram_we,
    input  logic [3:0]  alu_result,
    input  logic [3:0]  ram_dout,
    output logic        busy,
    output logic        done,
    output logic        res_valid,
    output logic [3:0]  res_data,
    output logic [3:0]  res_pc,
    output logic [3:0]  sig,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_WR   = 2'b01;
    localparam logic [1:0] K_RD   = 2'b10;
    localparam logic [1:0] K_HALT = 2'b11;

    state_t      state;
    state_t      state_next;
    logic [3:0]  pc;
    logic [3:0]  pc_next;
    logic [11:0] ir;
    logic [11:0] mem [16];

    logic [1:0] kind;
    logic [1:0] op;
    logic [3:0] f1;
    logic [3:0] f2;
    logic       active;

    assign kind = ir[11:10];
    assign op   = ir[9:8];
    assign f1   = ir[7:4];
    assign f2   = ir[3:0];

    assign dbg_state = state;

    // Program memory is deliberately not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= 4'd0;
            ir    <= 12'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state_next == ISSUE) begin
                ir <= mem[pc_next];
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    pc_next    = 4'd0;
                end
            end
            ISSUE:   state_next = (kind == K_HALT) ? DONE : SETTLE;
            SETTLE:  state_next = CAPTURE;
            CAPTURE: begin
                if (pc == LAST_PC) begin
                    state_next = DONE;
                end else begin
                    state_next = ISSUE;
                    pc_next    = pc + 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign active = (state == ISSUE) || (state == SETTLE) || (state == CAPTURE);

    // Operand fields are only meaningful while an instruction is in flight.
    always_comb begin
        A         = 4'd0;
        B         = 4'd0;
        opcode    = 2'd0;
        ram_addr  = 4'd0;
        ram_din   = 4'd0;
        ram_we    = 1'b0;
        res_valid = 1'b0;
        res_data  = 4'd0;
        res_pc    = 4'd0;
        if (active) begin
            case (kind)
                K_ALU: begin
                    A      = f1;
                    B      = f2;
                    opcode = op;
                end
                K_WR: begin
                    ram_addr = f1;
                    ram_din  = f2;
                    ram_we   = (state == ISSUE);
                end
                K_RD: begin
                    ram_addr = f1;
                end
                default: begin
                end
            endcase
        end
        if (state == CAPTURE && kind == K_ALU) begin
            res_valid = 1'b1;
            res_data  = alu_result;
            res_pc    = pc;
        end else if (state == CAPTURE && kind == K_RD) begin
            res_valid = 1'b1;
            res_data  = ram_dout;
            res_pc    = pc;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef UC_SEQ_SIG_EN
    logic [3:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 4'd0;
        end else if (state == IDLE && start) begin
            sig_q <= 4'd0;
        end else if (res_valid) begin
            sig_q <= sig_q ^ res_data;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 4'd0;
`endif

endmodule

// File: tb/tb_uc_sequencer.sv
// Bench for uc_sequencer: per-cycle vector tables on a LAST_PC=15 instance,
// plus a hand-written run on a LAST_PC=2 instance for automatic completion.
module tb_uc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;

    logic [3:0] a15, b15, ra15, rdin15, rd15, rpc15, sig15, alu15, rdout15;
    logic [1:0] op15;
    logic       we15, busy15, done15, rv15;
    logic [2:0] st15;

    logic [3:0] a2, b2, ra2, rdin2, rd2, rpc2, sig2, alu2, rdout2;
    logic [1:0] op2;
    logic       we2, busy2, done2, rv2;
    logic [2:0] st2;

    logic [3:0] ram15 [16];
    logic [3:0] ram2 [16];

    always #5 clk = ~clk;

    uc_sequencer dut15 (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .A(a15), .B(b15), .opcode(op15), .ram_addr(ra15), .ram_din(rdin15),
        .ram_we(we15), .alu_result(alu15), .ram_dout(rdout15),
        .busy(busy15), .done(done15), .res_valid(rv15), .res_data(rd15),
        .res_pc(rpc15), .sig(sig15), .dbg_state(st15)
    );

    uc_sequencer #(.LAST_PC(4'd2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .A(a2), .B(b2), .opcode(op2), .ram_addr(ra2), .ram_din(rdin2),
        .ram_we(we2), .alu_result(alu2), .ram_dout(rdout2),
        .busy(busy2), .done(done2), .res_valid(rv2), .res_data(rd2),
        .res_pc(rpc2), .sig(sig2), .dbg_state(st2)
    );

    // Microcontroller model: 00 add, 01 sub, 10 and, 11 or; async-read RAM.
    function automatic logic [3:0] alu_f(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        case (o)
            2'b00:   alu_f = x + y;
            2'b01:   alu_f = x - y;
            2'b10:   alu_f = x & y;
            default: alu_f = x | y;
        endcase
    endfunction

    assign alu15   = alu_f(op15, a15, b15);
    assign alu2    = alu_f(op2, a2, b2);
    assign rdout15 = ram15[ra15];
    assign rdout2  = ram2[ra2];

    always @(posedge clk) begin
        if (we15) ram15[ra15] <= rdin15;
        if (we2)  ram2[ra2]   <= rdin2;
    end

    // Observed output bundle: busy,done,res_valid,res_data,res_pc,A,B,opcode,ram_addr,ram_din,ram_we
    logic [29:0] act15, act2;
    assign act15 = {busy15, done15, rv15, rd15, rpc15, a15, b15, op15, ra15, rdin15, we15};
    assign act2  = {busy2, done2, rv2, rd2, rpc2, a2, b2, op2, ra2, rdin2, we2};

    typedef struct {
        logic        rst;
        logic        start;
        logic        pwe;
        logic [3:0]  paddr;
        logic [11:0] pdata;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [29:0] ex(input logic bsy, input logic dn, input logic rv,
                                       input logic [3:0] rd, input logic [3:0] rpc,
                                       input logic [3:0] xa, input logic [3:0] xb,
                                       input logic [1:0] xop, input logic [3:0] ra,
                                       input logic [3:0] rdin, input logic we);
        ex = {bsy, dn, rv, rd, rpc, xa, xb, xop, ra, rdin, we};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic pw,
                                input logic [3:0] pa, input logic [11:0] pd,
                                input logic [29:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.pwe = pw; v.paddr = pa; v.pdata = pd; v.exp = e;
        mk = v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [3:0] addr, input logic [11:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        step();
        prog_we = 1'b0; prog_addr = 4'd0; prog_data = 12'd0;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; start = tbl[i].start; prog_we = tbl[i].pwe;
            prog_addr = tbl[i].paddr; prog_data = tbl[i].pdata;
            step();
            check($sformatf("%s[%0d]", name, i), {2'b00, act15}, {2'b00, tbl[i].exp});
        end
        rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 12'd0;
        tbl.delete();
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) begin
            ram15[i] = 4'd0;
            ram2[i]  = 4'd0;
        end
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 12'd0;
        step();
        step();
        check("reset_out15", {2'b00, act15}, 32'd0);
        check("reset_out2", {2'b00, act2}, 32'd0);
        check("reset_state", {26'd0, st15, st2}, 32'd0);
        check("reset_sig", {24'd0, sig15, sig2}, 32'd0);
        rst = 1'b0;
        step();

        // ALU 5+3 then HALT
        prog(4'd0, 12'h053);
        prog(4'd1, 12'hC00);
        tbl.push_back(mk(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 1, 8, 0, 5, 3, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        run_table("alu_halt");

        // RAM write addr1 <= A, RAM read addr1, HALT
        prog(4'd0, 12'h41A);
        prog(4'd1, 12'h810);
        prog(4'd2, 12'hC00);
        tbl.push_back(mk(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 1, 4'hA, 1, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        run_table("ram_wr_rd");

        // Mid-instruction reset, ignored start/prog_we while busy, rst priority
        tbl.push_back(mk(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 1)));
        tbl.push_back(mk(0, 1, 1, 1, 12'hC00, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0)));
        tbl.push_back(mk(0, 1, 1, 1, 12'hC00, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 1, 4'hA, 1, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 1, 0, 12'hC00, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'hA, 1)));
        tbl.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        run_table("rst_ignore");

        // LAST_PC=2 instance: 0+1, 2+2, 7-3, then a trap instruction at pc 3
        prog(4'd0, 12'h001);
        prog(4'd1, 12'h022);
        prog(4'd2, 12'h173);
        prog(4'd3, 12'h00F);
        prog(4'd4, 12'hC00);
        exp_q = {8'h01, 8'h14, 8'h24};
        got_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        check("auto_sig_cleared", {28'd0, sig2}, 32'd0);
        cyc = 1;
        while (!done2 && cyc < 40) begin
            if (rv2) got_q.push_back({rpc2, rd2});
            step();
            cyc++;
        end
        check("auto_done_cycle", cyc, 32'd10);
        check("auto_pulse_count", got_q.size(), 32'd3);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hXX;
            check($sformatf("auto_result_pc%0d", e[7:4]), {24'd0, g}, {24'd0, e});
        end
`ifdef UC_SEQ_SIG_EN
        check("auto_sig", {28'd0, sig2}, 32'd1);
`else
        check("auto_sig", {28'd0, sig2}, 32'd0);
`endif
        step();
        check("auto_idle_after_done", {2'b00, act2}, 32'd0);
        cyc = 0;
        while (busy15 && cyc < 40) begin
            step();
            cyc++;
        end
        check("long_run_idle", {31'd0, busy15}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uc_sequencer.md
UC_SEQUENCER -- requirements
Module: uc_sequencer

Interface
REQ-001 SHALL have parameter LAST_PC, default 4'd15, meaning highest program address executed before automatic completion.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin program execution; sampled in IDLE only.
REQ-005 SHALL have port prog_we  input  1  program memory write strobe.
REQ-006 SHALL have port prog_addr  input  4  program memory write address.
REQ-007 SHALL have port prog_data  input  12  instruction word: [11:10] kind, [9:8] op, [7:4] f1, [3:0] f2.
REQ-008 SHALL have ports A, B  output  4 each  ALU operands to microcontroller.
REQ-009 SHALL have port opcode  output  2  ALU opcode to microcontroller.
REQ-010 SHALL have ports ram_addr, ram_din  output  4 each  and ram_we  output  1  RAM access to microcontroller.
REQ-011 SHALL have ports alu_result, ram_dout  input  4 each  results returned by microcontroller.
REQ-012 SHALL have ports busy  output  1, done  output  1, res_valid  output  1, res_data  output  4, res_pc  output  4.
REQ-013 SHALL have port sig  output  4  result signature (see Configuration).

Function
REQ-014 SHALL hold a 16x12 program memory written when prog_we=1 in IDLE; prog_we in any other state is ignored.
REQ-015 Instruction kinds SHALL be: 00 ALU (A=f1, B=f2, opcode=op), 01 RAM write (ram_addr=f1, ram_din=f2), 10 RAM read (ram_addr=f1), 11 HALT.
REQ-016 FSM states SHALL be IDLE, ISSUE, SETTLE, CAPTURE, DONE.
REQ-017 IDLE with start=1 SHALL go to ISSUE next cycle with pc=0; busy=1 in every state except IDLE.
REQ-018 On entry to ISSUE the instruction at mem[pc] SHALL be latched into an instruction register; A, B, opcode, ram_addr, ram_din SHALL be driven from it and held stable through SETTLE and CAPTURE.
REQ-019 Fields not used by the current kind SHALL be driven 0.
REQ-020 ram_we SHALL be 1 for exactly the ISSUE cycle of a RAM-write instruction, 0 otherwise.
REQ-021 ISSUE of HALT SHALL go directly to DONE; other kinds SHALL go ISSUE -> SETTLE -> CAPTURE (3 cycles per instruction).
REQ-022 In CAPTURE, ALU and RAM-read instructions SHALL pulse res_valid for one cycle with res_data = alu_result or ram_dout respectively and res_pc = pc; RAM write SHALL NOT assert res_valid.
REQ-023 From CAPTURE: pc==LAST_PC SHALL go to DONE; else pc increments by 1 and goes to ISSUE; pc never wraps.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; start during non-IDLE states SHALL be ignored.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, pc=0, and all outputs 0, from any state including mid-instruction.
REQ-026 rst SHALL NOT clear program memory contents.
REQ-027 rst SHALL take priority over start and prog_we in the same cycle.

Configuration
REQ-028 With UC_SEQ_SIG_EN defined, sig SHALL equal the XOR of all res_data values captured since the last start, cleared to 0 on start acceptance and on rst.
REQ-029 Without UC_SEQ_SIG_EN, sig SHALL be constant 0 and no signature register SHALL be implemented.

Verification
REQ-030 Load mem[0]=ALU op00 A=5 B=3, mem[1]=HALT; start -> A=5,B=3,opcode=00 from ISSUE; res_valid with res_data=8, res_pc=0; done pulses 4 cycles after ISSUE entry.
REQ-031 Program RAM write addr1 din 4'hA, RAM read addr1, HALT -> ram_we high one cycle only; res_data=4'hA, res_pc=1; exactly one res_valid pulse.
REQ-032 LAST_PC=2, three ALU instrs (0+1, 2+2, 7-3) with no HALT -> three res_valid pulses (1, 4, 4), done after pc=2, pc does not reach 3.
REQ-033 Assert rst in SETTLE of first instruction -> next cycle IDLE, busy=0, all outputs 0; start again reruns program from pc=0 with memory intact.
REQ-034 prog_we and start pulsed while busy -> memory unchanged, sequence unaffected; with UC_SEQ_SIG_EN, REQ-032 program gives sig=1^4^4=4'h1.
